dataval_forwarder: RTL and testbench

Transmit-side counterpart of the data + valid snooper: reads one packet out of packet memory and presents it as an AXI-stream-style flit stream (data/valid/ready/last). It sits between the packet memory read port and a downstream consumer (forwarding logic or test sink). When the final flit is accepted it signals `done` so the memory can release the buffer.

---
 rtl/dataval_forwarder.sv | 85 ++++++++
 tb/tb_dataval_forwarder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/dataval_forwarder.sv
// dataval_forwarder: reads one packet from packet memory and streams it as data/valid/ready/last flits
module dataval_forwarder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pkt_ready,
    input  logic [ADDR_WIDTH-1:0] pkt_len,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  done
);
    typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;
    state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] len, iss, pop;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic [1:0] count;
    logic [2:0] committed;
    logic wr_ptr, rd_ptr, inflight, pop_now;
    // entries the FIFO will hold next edge if nothing new is issued now; issuing is safe below 2
    assign committed = {1'b0, count} + {2'b0, inflight} - {2'b0, pop_now};
    assign out_valid = count != 2'd0;
    assign pop_now = out_valid && out_ready;
    assign out_data = out_valid ? fifo[rd_ptr] : '0;
    assign out_last = out_valid && (pop == len - ADDR_WIDTH'(1));
    assign rd_en = (state == READ) && (iss < len) && (committed < 3'd2);
    assign rd_addr = iss;
    assign done = (state == READ) && ((len == '0) || (pop_now && out_last));
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    // next state: start on pkt_ready, finish on done, then hold off one cycle in WAIT
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = pkt_ready ? READ : IDLE;
            READ:    state_nxt = done ? WAIT : READ;
            default: state_nxt = IDLE;
        endcase
    end
    // packet length capture plus issue and pop counters; addresses restart at 0 each packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len <= '0;
            iss <= '0;
            pop <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (state == IDLE && pkt_ready) begin
                len <= pkt_len;
                iss <= '0;
                pop <= '0;
            end else begin
                if (rd_en) iss <= iss + ADDR_WIDTH'(1);
                if (pop_now) pop <= pop + ADDR_WIDTH'(1);
            end
        end
    end
    // two-entry output FIFO: read data lands one cycle after issue, head leaves on each beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo[0] <= '0;
            fifo[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (inflight) begin
                fifo[wr_ptr] <= rd_data;
                wr_ptr <= ~wr_ptr;
            end
            if (pop_now) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop_now};
        end
    end
endmodule

// File: tb/tb_dataval_forwarder.sv
// tb_dataval_forwarder: randomized directed checks of the packet forwarder against a memory/stream model
module tb_dataval_forwarder;
    localparam bit [6:0] PAT = 7'b1101001;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pkt_ready = 1'b0;
    logic [9:0]  pkt_len = '0;
    logic [9:0]  rd_addr;
    logic        rd_en;
    logic [31:0] rd_data = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        done;
    logic [31:0] mem [1024];
    int n_tests = 0;
    int n_fail = 0;

    dataval_forwarder #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n), .pkt_ready(pkt_ready), .pkt_len(pkt_len),
        .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    // synchronous-read packet memory: data valid the cycle after rd_en
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // mode: 0 = ready always high, 1 = fixed 1,0,0,1,0,1,1 pattern, 2 = random ready
    task automatic run_packet(input int len, input int mode);
        int issued = 0;
        int beats = 0;
        int c = 0;
        bit fin = 1'b0;
        bit stall = 1'b0;
        bit exp_done;
        for (int i = 0; i < len; i++) mem[i] = $urandom;
        pkt_len = 10'(len);
        pkt_ready = 1'b1;
        while (!fin && c < 8 * len + 20) begin
            @(negedge clk);
            pkt_ready = 1'($urandom_range(0, 1));
            pkt_len = 10'($urandom);
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? PAT[c % 7] : 1'($urandom_range(0, 1));
            #1;
            if (c == 0) check("start_rd_en", 32'(rd_en), 32'(len != 0));
            if (c < 2) check("early_valid", 32'(out_valid), 32'd0);
            if (c == 2 && len != 0) check("first_valid", 32'(out_valid), 32'd1);
            if (stall) check("stall_hold_valid", 32'(out_valid), 32'd1);
            if (rd_en) begin
                check("rd_addr", 32'(rd_addr), 32'(issued));
                check("rd_in_range", 32'(issued < len), 32'd1);
                issued++;
            end
            if (out_valid) begin
                check("out_data", out_data, mem[beats]);
                check("out_last", 32'(out_last), 32'(beats == len - 1));
            end
            exp_done = len == 0 ? c == 0 : (out_valid && out_ready && beats == len - 1);
            check("done", 32'(done), 32'(exp_done));
            stall = out_valid && !out_ready;
            if (out_valid && out_ready) beats++;
            check("occupancy", 32'(issued - beats <= 2), 32'd1);
            fin = done || exp_done;
            c++;
        end
        check("timeout", 32'(fin), 32'd1);
        check("beat_count", 32'(beats), 32'(len));
        check("read_count", 32'(issued), 32'(len));
        if (mode == 0) check("done_cycle", 32'(c - 1), 32'(len == 0 ? 0 : len + 1));
        @(negedge clk);
        pkt_ready = 1'b1;
        #1;
        check_quiet("wait");
        @(negedge clk);
        pkt_ready = 1'b0;
        #1;
        check_quiet("idle");
    endtask

    initial begin
        int b;
        repeat (2) @(negedge clk);
        #1;
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_quiet("idle_after_rst");
        run_packet(4, 0);
        run_packet(6, 1);
        run_packet(1, 0);
        run_packet(0, 0);
        run_packet(3, 0);
        run_packet(2, 0);
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        pkt_len = 10'd8;
        pkt_ready = 1'b1;
        b = 0;
        for (int k = 0; k < 12 && b < 2; k++) begin
            @(negedge clk);
            pkt_ready = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid && out_ready) b++;
        end
        check("pre_reset_beats", 32'(b), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 32'(out_valid), 32'd0);
        check("async_rst_rd_en", 32'(rd_en), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check("async_rst_rd_addr", 32'(rd_addr), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        run_packet(2, 0);
        for (int i = 0; i < 8; i++) run_packet($urandom_range(0, 20), 2);
        run_packet(200, 2);
        run_packet(50, 1);
        run_packet(30, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
